// File: rtl/demux_1to16_reg.sv
// demux_1to16_reg: registered 1-to-16 byte distributor with a valid/ready input,
// per-channel full flags cleared by downstream acks, and a sequential write pointer.
module demux_1to16_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [3:0]       sel,
    input  logic             mode,
    input  logic             flush,
    input  logic [15:0]      ack,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7,
    output logic [WIDTH-1:0] Q8,
    output logic [WIDTH-1:0] Q9,
    output logic [WIDTH-1:0] Q10,
    output logic [WIDTH-1:0] Q11,
    output logic [WIDTH-1:0] Q12,
    output logic [WIDTH-1:0] Q13,
    output logic [WIDTH-1:0] Q14,
    output logic [WIDTH-1:0] Q15,
    output logic [15:0]      full,
    output logic [3:0]       ptr
);

    logic [15:0][WIDTH-1:0] q_q, q_d;
    logic [15:0]            full_q, full_d;
    logic [3:0]             ptr_q, ptr_d;
    logic [3:0]             target;
    logic                   accept;

    // Pick the target channel and decide whether it can take a byte this cycle;
    // an ack on the target frees it in the same cycle so a channel can be refilled every cycle.
    always_comb begin
        target    = mode ? ptr_q : sel;
        din_ready = ~flush & (~full_q[target] | ack[target]);
        accept    = din_valid & din_ready;
    end

    // Next-state: acks clear flags, a write sets its flag after acks so the write wins,
    // and flush clears every flag and the pointer while leaving the data registers alone.
    always_comb begin
        q_d    = q_q;
        full_d = full_q & ~ack;
        ptr_d  = ptr_q;
        if (flush) begin
            full_d = '0;
            ptr_d  = '0;
        end else if (accept) begin
            q_d[target]    = din;
            full_d[target] = 1'b1;
            if (mode) begin
                ptr_d = ptr_q + 4'd1;
            end
        end
    end

    // State registers; reset wipes all held data immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            full_q <= '0;
            ptr_q  <= '0;
        end else begin
            q_q    <= q_d;
            full_q <= full_d;
            ptr_q  <= ptr_d;
        end
    end

    assign full = full_q;
    assign ptr  = ptr_q;
    assign Q0   = q_q[0];
    assign Q1   = q_q[1];
    assign Q2   = q_q[2];
    assign Q3   = q_q[3];
    assign Q4   = q_q[4];
    assign Q5   = q_q[5];
    assign Q6   = q_q[6];
    assign Q7   = q_q[7];
    assign Q8   = q_q[8];
    assign Q9   = q_q[9];
    assign Q10  = q_q[10];
    assign Q11  = q_q[11];
    assign Q12  = q_q[12];
    assign Q13  = q_q[13];
    assign Q14  = q_q[14];
    assign Q15  = q_q[15];

endmodule

// File: tb/tb_demux_1to16_reg.sv
// tb_demux_1to16_reg: table-driven directed test of the 1-to-16 registered distributor.
module tb_demux_1to16_reg;

    typedef struct {
        logic [7:0]  din;
        logic        valid;
        logic [3:0]  sel;
        logic        mode;
        logic        flush;
        logic [15:0] ack;
        logic        exp_ready;
        int          chan;
        logic [7:0]  exp_q;
        logic [15:0] exp_full;
        logic [3:0]  exp_ptr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [3:0]  sel;
    logic        mode;
    logic        flush;
    logic [15:0] ack;
    logic [7:0]  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15;
    logic [15:0] full;
    logic [3:0]  ptr;
    logic [7:0]  q_arr [16];

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    demux_1to16_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sel(sel), .mode(mode), .flush(flush), .ack(ack),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
        .Q8(Q8), .Q9(Q9), .Q10(Q10), .Q11(Q11), .Q12(Q12), .Q13(Q13), .Q14(Q14), .Q15(Q15),
        .full(full), .ptr(ptr)
    );

    always #5 clk = ~clk;

    always_comb begin
        q_arr[0]  = Q0;  q_arr[1]  = Q1;  q_arr[2]  = Q2;  q_arr[3]  = Q3;
        q_arr[4]  = Q4;  q_arr[5]  = Q5;  q_arr[6]  = Q6;  q_arr[7]  = Q7;
        q_arr[8]  = Q8;  q_arr[9]  = Q9;  q_arr[10] = Q10; q_arr[11] = Q11;
        q_arr[12] = Q12; q_arr[13] = Q13; q_arr[14] = Q14; q_arr[15] = Q15;
    end

    function automatic vec_t mkVec(input logic [7:0] d, input logic v, input logic [3:0] s,
                                   input logic m, input logic f, input logic [15:0] a,
                                   input logic er, input int ch, input logic [7:0] eq,
                                   input logic [15:0] ef, input logic [3:0] ep);
        vec_t r;
        r.din = d; r.valid = v; r.sel = s; r.mode = m; r.flush = f; r.ack = a;
        r.exp_ready = er; r.chan = ch; r.exp_q = eq; r.exp_full = ef; r.exp_ptr = ep;
        return r;
    endfunction

    function automatic logic [15:0] lowMask(input int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return m[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one vector just after a rising edge, check ready before the next edge,
    // then check flags, pointer and the addressed channel just after that edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        din = v.din; din_valid = v.valid; sel = v.sel; mode = v.mode;
        flush = v.flush; ack = v.ack;
        #3;
        tag = $sformatf("v%0d_ready", idx);
        checkOutput(tag, {31'd0, din_ready}, {31'd0, v.exp_ready});
        @(posedge clk);
        #1;
        tag = $sformatf("v%0d_full", idx);
        checkOutput(tag, {16'd0, full}, {16'd0, v.exp_full});
        tag = $sformatf("v%0d_ptr", idx);
        checkOutput(tag, {28'd0, ptr}, {28'd0, v.exp_ptr});
        tag = $sformatf("v%0d_q%0d", idx, v.chan);
        checkOutput(tag, {24'd0, q_arr[v.chan]}, {24'd0, v.exp_q});
    endtask

    task automatic runTable(input int base);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], base + i);
        end
        din_valid = 1'b0; ack = '0; flush = 1'b0;
        vecs.delete();
    endtask

    initial begin
        rst_n = 1'b1; din = '0; din_valid = 1'b0; sel = '0; mode = 1'b0; flush = 1'b0; ack = '0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst0_full", {16'd0, full}, 32'd0);
        checkOutput("rst0_ptr", {28'd0, ptr}, 32'd0);
        checkOutput("rst0_q0", {24'd0, Q0}, 32'd0);
        checkOutput("rst0_ready", {31'd0, din_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Phase A: addressed writes, spurious ack, write+ack, flush priority, acked fill.
        vecs.push_back(mkVec(8'hA5, 1, 4'd3,  0, 0, 16'h0000, 1, 3,  8'hA5, 16'h0008, 4'd0));
        vecs.push_back(mkVec(8'h5A, 1, 4'd12, 0, 0, 16'h0000, 1, 12, 8'h5A, 16'h1008, 4'd0));
        vecs.push_back(mkVec(8'hB7, 1, 4'd3,  0, 0, 16'h0000, 0, 3,  8'hA5, 16'h1008, 4'd0));
        vecs.push_back(mkVec(8'h00, 0, 4'd0,  0, 0, 16'h1008, 1, 3,  8'hA5, 16'h0000, 4'd0));
        vecs.push_back(mkVec(8'h00, 0, 4'd0,  0, 0, 16'hFFFF, 1, 12, 8'h5A, 16'h0000, 4'd0));
        vecs.push_back(mkVec(8'h11, 1, 4'd5,  0, 0, 16'h0000, 1, 5,  8'h11, 16'h0020, 4'd0));
        vecs.push_back(mkVec(8'h22, 1, 4'd5,  0, 0, 16'h0020, 1, 5,  8'h22, 16'h0020, 4'd0));
        vecs.push_back(mkVec(8'h00, 0, 4'd0,  0, 0, 16'h0020, 1, 5,  8'h22, 16'h0000, 4'd0));
        for (int k = 0; k < 7; k++)
            vecs.push_back(mkVec(8'h30 + 8'(k), 1, 4'd0, 1, 0, 16'h0000, 1, k, 8'h30 + 8'(k),
                                 lowMask(k + 1), 4'(k + 1)));
        vecs.push_back(mkVec(8'h77, 1, 4'd7, 0, 0, 16'h000F, 1, 7, 8'h77, 16'h00F0, 4'd7));
        vecs.push_back(mkVec(8'hEE, 1, 4'd0, 1, 1, 16'h0010, 0, 7, 8'h77, 16'h0000, 4'd0));
        for (int k = 0; k < 17; k++)
            vecs.push_back(mkVec(8'(k), 1, 4'd0, 1, 0, 16'(32'd1 << (k % 16)), 1, k % 16, 8'(k),
                                 (k < 16) ? lowMask(k + 1) : 16'hFFFF, 4'((k + 1) % 16)));
        runTable(0);
        for (int c = 1; c < 16; c++)
            checkOutput($sformatf("fill_q%0d", c), {24'd0, q_arr[c]}, c);
        checkOutput("fill_q4_after_flush", {24'd0, Q4}, 32'h04);

        // Phase B: unacked fill stalls, then set up full=FFFF with ptr=9 for the reset test.
        vecs.push_back(mkVec(8'h00, 0, 4'd0, 1, 1, 16'h0000, 0, 0, 8'h10, 16'h0000, 4'd0));
        for (int k = 0; k < 16; k++)
            vecs.push_back(mkVec(8'h40 + 8'(k), 1, 4'd0, 1, 0, 16'h0000, 1, k, 8'h40 + 8'(k),
                                 lowMask(k + 1), 4'((k + 1) % 16)));
        vecs.push_back(mkVec(8'h50, 1, 4'd0, 1, 0, 16'h0000, 0, 0, 8'h40, 16'hFFFF, 4'd0));
        vecs.push_back(mkVec(8'h00, 0, 4'd0, 1, 1, 16'h0000, 0, 0, 8'h40, 16'h0000, 4'd0));
        for (int k = 0; k < 9; k++)
            vecs.push_back(mkVec(8'h60 + 8'(k), 1, 4'd0, 1, 0, 16'h0000, 1, k, 8'h60 + 8'(k),
                                 lowMask(k + 1), 4'(k + 1)));
        for (int j = 0; j < 7; j++)
            vecs.push_back(mkVec(8'h70 + 8'(j), 1, 4'(9 + j), 0, 0, 16'h0000, 1, 9 + j,
                                 8'h70 + 8'(j), lowMask(10 + j), 4'd9));
        runTable(100);

        // Mid-cycle asynchronous reset with everything full and ptr=9.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_full", {16'd0, full}, 32'd0);
        checkOutput("arst_ptr", {28'd0, ptr}, 32'd0);
        for (int c = 0; c < 16; c++)
            checkOutput($sformatf("arst_q%0d", c), {24'd0, q_arr[c]}, 32'd0);
        flush = 1'b1;
        #1;
        checkOutput("arst_flush_ready", {31'd0, din_ready}, 32'd0);
        flush = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1;
        checkOutput("arst_ready", {31'd0, din_ready}, 32'd1);

        // First accept on the first edge after release.
        din = 8'h9C; din_valid = 1'b1; sel = 4'd2; mode = 1'b0;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        checkOutput("post_rst_q2", {24'd0, Q2}, 32'h9C);
        checkOutput("post_rst_full", {16'd0, full}, 32'h0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
